// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
// Imported by the responder top and its storage array.
package dmem_responder_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

  localparam logic LOAD  = 1'b0;
  localparam logic STORE = 1'b1;

endpackage

// File: rtl/dmem_responder_array.sv
// Synchronous single-port word array with registered read data.
// Storage is never reset; only the read register is.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int IDX_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic              zero_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[idx_i] <= wdata_i;
  end

  // zero_i masks the read of an out-of-range index
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rdata_o <= '0;
    end else if (re_i) begin
      rdata_o <= zero_i ? '0 : mem[idx_i];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory slave: accepts one request, waits
// LATENCY cycles, then pulses ack with read data and error flag.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 32,
  parameter int          LATENCY     = 4,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [31:0]       addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              ready_o,
  output logic              busy_o,
  output logic              ack_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o
);

  localparam int IDX_W =
    (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  if (LATENCY < 1 || LATENCY > 15) begin : g_lat_chk
    $error("dmem_responder: LATENCY must be 1..15");
  end

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              accept;
  logic              we_q;
  logic [31:0]       addr_q;
  logic [DATA_W-1:0] wdata_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= LOAD;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= we_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
      end
    end
  end

  // With LATENCY 1, RESP is entered on the accepting edge,
  // so the request must come straight from the inputs.
  logic              idle;
  logic              cur_we;
  logic [31:0]       cur_addr;
  logic [DATA_W-1:0] cur_wdata;

  assign idle      = (state_q == IDLE);
  assign cur_we    = idle ? we_i    : we_q;
  assign cur_addr  = idle ? addr_i  : addr_q;
  assign cur_wdata = idle ? wdata_i : wdata_q;

  logic        borrow;
  logic [31:0] off;
  logic [31:0] word;
  logic        bad;
  logic        enter_resp;

  assign {borrow, off} = {1'b0, cur_addr} - {1'b0, BASE_ADDR};
  assign word = off >> 2;
  assign bad  = (cur_addr[1:0] != 2'b00) || borrow ||
                (word >= 32'(DEPTH_WORDS));

  assign enter_resp = (state_d == RESP) && (state_q != RESP);

  dmem_array #(
    .DEPTH (DEPTH_WORDS),
    .IDX_W (IDX_W)
  ) u_array (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (enter_resp && (cur_we == STORE) && !bad),
    .re_i    (enter_resp && (cur_we == LOAD)),
    .zero_i  (bad),
    .idx_i   (IDX_W'(word)),
    .wdata_i (cur_wdata),
    .rdata_o (rdata_o)
  );

  assign ready_o = idle;
  assign busy_o  = !idle;
  assign ack_o   = (state_q == RESP);
  assign err_o   = ack_o && bad;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY 4 and LATENCY 1
// instances share clock and reset.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        req = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic        ready, busy, ack, err;
  logic [31:0] rdata;

  logic        req1 = 1'b0, we1 = 1'b0;
  logic [31:0] addr1 = '0, wdata1 = '0;
  logic        ready1, busy1, ack1, err1;
  logic [31:0] rdata1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_responder #(
    .DEPTH_WORDS (32),
    .LATENCY     (4),
    .BASE_ADDR   (32'h0)
  ) u_dut (
    .clk_i   (clk),
    .rst_i   (rst_n),
    .req_i   (req),
    .we_i    (we),
    .addr_i  (addr),
    .wdata_i (wdata),
    .ready_o (ready),
    .busy_o  (busy),
    .ack_o   (ack),
    .rdata_o (rdata),
    .err_o   (err)
  );

  dmem_responder #(
    .DEPTH_WORDS (32),
    .LATENCY     (1),
    .BASE_ADDR   (32'h0)
  ) u_dut1 (
    .clk_i   (clk),
    .rst_i   (rst_n),
    .req_i   (req1),
    .we_i    (we1),
    .addr_i  (addr1),
    .wdata_i (wdata1),
    .ready_o (ready1),
    .busy_o  (busy1),
    .ack_o   (ack1),
    .rdata_o (rdata1),
    .err_o   (err1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Single request on the LATENCY 4 port. The ack cycle starts
  // 3 edges after the accepting edge (4 cycles after acceptance).
  task automatic xfer(input string tag,
                      input logic w,
                      input logic [31:0] a,
                      input logic [31:0] d,
                      input logic exp_err,
                      input logic [31:0] exp_rd);
    int n;
    chk({tag, " ready"}, 32'(ready), 32'd1);
    we = w; addr = a; wdata = d; req = 1'b1;
    tick();
    req = 1'b0; we = ~w;
    addr = 32'hFFFF_FFFF; wdata = 32'h0BAD_0BAD;
    chk({tag, " busy"}, 32'(busy), 32'd1);
    n = 0;
    while (!ack && n < 20) begin
      tick();
      n++;
    end
    chk({tag, " lat"}, 32'(n), 32'd3);
    chk({tag, " err"}, 32'(err), 32'(exp_err));
    chk({tag, " rdata"}, rdata, exp_rd);
    tick();
    chk({tag, " ack1"}, 32'(ack), 32'd0);
    chk({tag, " err0"}, 32'(err), 32'd0);
  endtask

  logic [31:0] la [3];
  logic [31:0] ld [3];
  int          acc [3];
  int          t, na, nk, n;
  logic        take;

  initial begin
    // reset and idle
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst ready", 32'(ready), 32'd1);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst ack", 32'(ack), 32'd0);
    chk("rst rdata", rdata, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle ready", 32'(ready), 32'd1);
      chk("idle busy", 32'(busy), 32'd0);
      chk("idle ack", 32'(ack), 32'd0);
      chk("idle rdata", rdata, 32'd0);
    end

    // store / load and address checks
    xfer("st10", 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0);
    xfer("ld10", 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF);
    xfer("st12", 1'b1, 32'h12, 32'h1111_1111, 1'b1, 32'hDEAD_BEEF);
    xfer("ld80", 1'b0, 32'h80, 32'h0, 1'b1, 32'h0);
    xfer("ld10b", 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF);
    xfer("st7c", 1'b1, 32'h7C, 32'h7777_7777, 1'b0, 32'hDEAD_BEEF);
    xfer("ld7c", 1'b0, 32'h7C, 32'h0, 1'b0, 32'h7777_7777);
    xfer("st14", 1'b1, 32'h14, 32'h0123_4567, 1'b0, 32'h7777_7777);
    xfer("st20", 1'b1, 32'h20, 32'hAAAA_5555, 1'b0, 32'h7777_7777);

    // req held high across three loads
    la[0] = 32'h10; ld[0] = 32'hDEAD_BEEF;
    la[1] = 32'h14; ld[1] = 32'h0123_4567;
    la[2] = 32'h20; ld[2] = 32'hAAAA_5555;
    t = 0; na = 0; nk = 0;
    req = 1'b1; we = 1'b0; addr = la[0];
    while ((na < 3 || nk < 3) && t < 60) begin
      take = req && ready;
      tick();
      t++;
      if (take) begin
        acc[na] = t;
        chk("hold busy", 32'(busy), 32'd1);
        na++;
        if (na < 3) addr = la[na];
        else req = 1'b0;
      end
      if (ack) begin
        if (nk < 3) chk("hold rdata", rdata, ld[nk]);
        nk++;
      end
    end
    req = 1'b0;
    chk("hold accepts", 32'(na), 32'd3);
    chk("hold acks", 32'(nk), 32'd3);
    if (na == 3) begin
      chk("hold gap1", 32'(acc[1] - acc[0]), 32'd5);
      chk("hold gap2", 32'(acc[2] - acc[1]), 32'd5);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ack) nk++;
    end
    chk("hold no extra", 32'(nk), 32'd3);

    // reset during WAIT aborts the store
    we = 1'b1; addr = 32'h20; wdata = 32'h1234_5678; req = 1'b1;
    tick();
    req = 1'b0;
    chk("abort busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort ready", 32'(ready), 32'd1);
    chk("abort busyr", 32'(busy), 32'd0);
    chk("abort ack", 32'(ack), 32'd0);
    chk("abort rdata", rdata, 32'd0);
    tick();
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ack) n++;
    end
    chk("abort no ack", 32'(n), 32'd0);
    xfer("ld20", 1'b0, 32'h20, 32'h0, 1'b0, 32'hAAAA_5555);

    // LATENCY 1 instance
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h8; wdata1 = 32'h5A5A_5A5A;
    tick();
    req1 = 1'b0; addr1 = 32'h0;
    chk("l1 st ack", 32'(ack1), 32'd1);
    chk("l1 st err", 32'(err1), 32'd0);
    tick();
    chk("l1 ready", 32'(ready1), 32'd1);
    t = 0; na = 0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h8;
    while (na < 2 && t < 10) begin
      take = req1 && ready1;
      tick();
      t++;
      if (take) begin
        acc[na] = t;
        chk("l1 ld ack", 32'(ack1), 32'd1);
        chk("l1 ld rdata", rdata1, 32'h5A5A_5A5A);
        na++;
      end
    end
    req1 = 1'b0;
    chk("l1 accepts", 32'(na), 32'd2);
    if (na == 2) chk("l1 gap", 32'(acc[1] - acc[0]), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
